// File: rtl/vote_collector_if.sv
// Ballot-collection bus between a vote source/ballot consumer and vote_collector.
// The master side offers votes and acknowledges ballots; the slave side is the collector.
interface vote_collector_if;
  logic       open;
  logic       vote_valid;
  logic [1:0] vote_id;
  logic       vote_yes;
  logic       vote_ready;
  logic [3:0] ballot;
  logic       ballot_valid;
  logic       ballot_ack;
  logic [3:0] received;
  logic       timed_out;
  logic       dup_err;

  modport master (
    output open,
    output vote_valid,
    output vote_id,
    output vote_yes,
    output ballot_ack,
    input  vote_ready,
    input  ballot,
    input  ballot_valid,
    input  received,
    input  timed_out,
    input  dup_err
  );

  modport slave (
    input  open,
    input  vote_valid,
    input  vote_id,
    input  vote_yes,
    input  ballot_ack,
    output vote_ready,
    output ballot,
    output ballot_valid,
    output received,
    output timed_out,
    output dup_err
  );
endinterface

// File: rtl/vote_collector.sv
// Sequential front end for the four-input voter: opens a round, collects one ballot bit per
// voter, closes on full mask or timeout, and holds the ballot word until acknowledged.
module vote_collector #(
  parameter int unsigned TIMEOUT    = 16,
  parameter logic        ABSENT_VAL = 1'b0
) (
  input logic             clk,
  input logic             rst,
  vote_collector_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StPresent
  } state_e;

  localparam logic [7:0] TimerInit = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] ballot_q, ballot_d;
  logic [3:0] received_q, received_d;
  logic       timed_out_q, timed_out_d;
  logic       dup_err_q, dup_err_d;

  logic [3:0] id_onehot;
  logic       vote_fire;
  logic       is_dup;

  always_comb begin
    id_onehot = 4'b0001 << bus.vote_id;
    vote_fire = bus.vote_valid && (state_q == StCollect);
    is_dup    = vote_fire && ((received_q & id_onehot) != 4'b0000);

    state_d     = state_q;
    timer_d     = timer_q;
    ballot_d    = ballot_q;
    received_d  = received_q;
    timed_out_d = timed_out_q;
    dup_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.open) begin
          state_d     = StCollect;
          timer_d     = TimerInit;
          ballot_d    = 4'b0000;
          received_d  = 4'b0000;
          timed_out_d = 1'b0;
        end
      end

      StCollect: begin
        if (timer_q != 8'd0) begin
          timer_d = timer_q - 8'd1;
        end
        // First vote per voter wins; later ones only raise dup_err.
        if (vote_fire && !is_dup) begin
          received_d = received_q | id_onehot;
          ballot_d   = (ballot_q & ~id_onehot) | ({4{bus.vote_yes}} & id_onehot);
        end
        dup_err_d = is_dup;

        // A vote completing the mask on the last timer cycle beats the timeout.
        if (received_d == 4'b1111) begin
          state_d = StPresent;
        end else if (timer_q == 8'd0) begin
          state_d     = StPresent;
          timed_out_d = 1'b1;
          ballot_d    = (ballot_d & received_d) | ({4{ABSENT_VAL}} & ~received_d);
        end
      end

      StPresent: begin
        if (bus.ballot_ack) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= 8'd0;
      ballot_q    <= 4'b0000;
      received_q  <= 4'b0000;
      timed_out_q <= 1'b0;
      dup_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ballot_q    <= ballot_d;
      received_q  <= received_d;
      timed_out_q <= timed_out_d;
      dup_err_q   <= dup_err_d;
    end
  end

  assign bus.vote_ready   = (state_q == StCollect);
  assign bus.ballot_valid = (state_q == StPresent);
  assign bus.ballot       = ballot_q;
  assign bus.received     = received_q;
  assign bus.timed_out    = timed_out_q;
  assign bus.dup_err      = dup_err_q;

  // The consumer relies on the ballot word not moving while it is presented.
  ballot_stable_a : assert property (
    @(posedge clk) disable iff (rst)
    (state_q == StPresent && !bus.ballot_ack) |=> (ballot_q == $past(ballot_q))
  );

endmodule

// File: doc/vote_collector.md
# vote_collector

Sequential front end for the four-input voter. It opens a voting round, collects one yes/no ballot from each of four voters over a valid/ready handshake, and assembles the 4-bit ballot word. It then presents that word, held stable, to the voter's `I` input until acknowledged. A round closes when all four votes arrive or a timeout expires; missing votes are filled with a fixed absent value.

## Interface

Parameters:
- `TIMEOUT`, 16: maximum number of cycles spent in COLLECT per round; range 1..255.
- `ABSENT_VAL`, 1'b0: ballot bit substituted for any voter that did not vote before timeout.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `open`, input, 1: start-of-round pulse; honoured only in IDLE.
- `vote_valid`, input, 1: a vote is offered this cycle.
- `vote_id`, input, 2: voter index 0..3; selects bit `ballot[vote_id]`.
- `vote_yes`, input, 1: vote value (1 = yes).
- `vote_ready`, output, 1: collector accepts votes this cycle.
- `ballot`, output, 4: assembled ballot word; connects to voter `I`.
- `ballot_valid`, output, 1: `ballot` is final and stable.
- `ballot_ack`, input, 1: consumer has sampled `ballot`.
- `received`, output, 4: mask of voters whose vote was accepted this round.
- `timed_out`, output, 1: current or last round closed by timeout with `received != 4'b1111`.
- `dup_err`, output, 1: one-cycle pulse on a rejected duplicate vote.

## Operation

- The FSM has three states: IDLE, COLLECT and PRESENT.
- **IDLE**
  - `vote_ready=0`, `ballot_valid=0`; `ballot`, `received` and `timed_out` hold the previous round's values.
  - On `open=1`, go to COLLECT. On the same edge: clear `ballot` to 4'b0000, `received` and `timed_out` to 0, and load the timer with `TIMEOUT-1`.
- **COLLECT**
  - `vote_ready=1`. A vote is accepted when `vote_valid & vote_ready`.
  - If `received[vote_id]==0`: set `ballot[vote_id]=vote_yes` and `received[vote_id]=1`.
  - If `received[vote_id]==1`: ballot unchanged (first vote wins), and `dup_err` pulses high for one cycle starting the next cycle.
  - The timer decrements each COLLECT cycle.
  - Exit to PRESENT on the edge where `received` becomes 4'b1111, or where the timer is 0, whichever comes first.
  - On a timeout exit with the mask still incomplete: every bit with `received[i]==0` is set to `ABSENT_VAL` and `timed_out` is set to 1.
- **PRESENT**
  - `vote_ready=0`, `ballot_valid=1`; `ballot` is stable.
  - On `ballot_ack=1`, go to IDLE. `open` is ignored.
- `open` outside IDLE has no effect. `vote_valid` outside COLLECT is ignored, with no `dup_err`.
- Reset forces IDLE. All outputs become 0: `ballot=4'b0000`, `received=4'b0000`, `ballot_valid`, `vote_ready`, `timed_out`, `dup_err`. Reset applied mid-round discards the round, and no `ballot_valid` is produced for it.

## Timing

- `open` sampled at edge E0: `vote_ready` is high from the cycle after E0.
- A vote accepted at edge E: `received`/`ballot` are updated in the cycle after E.
- Fourth distinct vote accepted at edge E: `ballot_valid=1` in the cycle after E. Latency from last vote to valid is 1 cycle.
- COLLECT lasts at most `TIMEOUT` cycles.
  - With no votes, `ballot_valid` rises exactly `TIMEOUT+1` cycles after the `open` edge.
- Simultaneous events:
  - A vote completing the mask on the timer==0 edge is counted, and `timed_out` stays 0.
  - A non-completing vote on the timer==0 edge is counted; the remaining absent bits are filled and `timed_out=1`.
- `ballot_ack` is sampled only in PRESENT. It must be high for at least one cycle.
  - If `ballot_ack` is held high in the first PRESENT cycle, `ballot_valid` is high for exactly 1 cycle.
- `dup_err` is registered: one cycle late relative to the offending vote, and never asserted outside the cycle after a COLLECT rejection.

## Test plan

- **Reset:** assert `rst` 2 cycles during COLLECT with `received=4'b0011` → all outputs 0 next cycle, state IDLE, no `ballot_valid`.
- **Full round:** `open`, then votes (id,yes) = (0,1),(1,0),(2,1),(3,1) on consecutive cycles → `ballot=4'b1101`, `received=4'b1111`, `ballot_valid` 1 cycle after the 4th vote, `timed_out=0`; `ballot_ack` → IDLE.
- **Timeout, absent fill:** `TIMEOUT=16`, `ABSENT_VAL=0`; `open`, votes (1,1) and (3,1) only → `ballot_valid` 17 cycles after `open`, `ballot=4'b1010`, `timed_out=1`, `received=4'b1010`.
- **Duplicate:** votes (2,1) then (2,0) → `ballot[2]=1` retained, `dup_err` high exactly one cycle after the second vote, round still completes normally.
- **Edge race:** the 4th vote arrives on the timer==0 cycle → `timed_out=0`, `ballot` reflects all four votes.
- **Exhaustive sweep:** all 16 ballot combinations driven as four votes each → `ballot` equals the driven pattern for each, matching the voter input sequence 4'b0000..4'b1111.
